// File: rtl/tokenizer_pkg.sv
// tokenizer_pkg: token codes, lexer states and ASCII ranges shared by the lexer and the nesting checker
package tokenizer_pkg;

    typedef logic [1:0] tok_t;

    localparam tok_t TOK_OTHER = 2'd0;
    localparam tok_t TOK_BEGIN = 2'd1;
    localparam tok_t TOK_END   = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE, S_B, S_BE, S_BEG, S_BEGI, S_BEGIN, S_E, S_EN, S_END, S_OTHER
    } state_t;

    localparam logic [7:0] UPPER_LO = 8'h41;
    localparam logic [7:0] UPPER_HI = 8'h5A;
    localparam logic [7:0] LOWER_LO = 8'h61;
    localparam logic [7:0] LOWER_HI = 8'h7A;

    // Next keyword-match state for a folded letter; any miss falls into S_OTHER for the rest of the word
    function automatic state_t next_state(input state_t s, input logic [7:0] c);
        case (s)
            S_IDLE:  return c == "b" ? S_B : c == "e" ? S_E : S_OTHER;
            S_B:     return c == "e" ? S_BE    : S_OTHER;
            S_BE:    return c == "g" ? S_BEG   : S_OTHER;
            S_BEG:   return c == "i" ? S_BEGI  : S_OTHER;
            S_BEGI:  return c == "n" ? S_BEGIN : S_OTHER;
            S_E:     return c == "n" ? S_EN    : S_OTHER;
            S_EN:    return c == "d" ? S_END   : S_OTHER;
            default: return S_OTHER;
        endcase
    endfunction

    // Only complete keywords classify; prefixes and extensions are ordinary words
    function automatic tok_t tok_of(input state_t s);
        return s == S_BEGIN ? TOK_BEGIN : s == S_END ? TOK_END : TOK_OTHER;
    endfunction

endpackage

// File: rtl/char_classifier.sv
// char_classifier: flags ASCII letters and folds them to lower case, passing other bytes through
module char_classifier
    import tokenizer_pkg::*;
(
    input  logic [7:0] ch,
    output logic       is_letter,
    output logic [7:0] folded
);

    // Setting bit 5 lower-cases a letter; it is applied to letters only so delimiters stay intact
    always_comb begin
        is_letter = (ch >= UPPER_LO && ch <= UPPER_HI) || (ch >= LOWER_LO && ch <= LOWER_HI);
        folded    = is_letter ? (ch | 8'h20) : ch;
    end

endmodule

// File: rtl/keyword_tokenizer.sv
// keyword_tokenizer: splits a character stream into words and strobes a BEGIN/END/OTHER token per word
module keyword_tokenizer
    import tokenizer_pkg::*;
#(
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in,
    input  logic             in_valid,
    output logic             tok_valid,
    output tok_t             tok,
    output logic [LEN_W-1:0] word_len
);

    logic             is_letter;
    logic [7:0]       folded;
    state_t           state;
    logic [LEN_W-1:0] len;

    char_classifier u_class (
        .ch       (in),
        .is_letter(is_letter),
        .folded   (folded)
    );

    // Letters advance the matcher and the saturating length; the first delimiter after a word emits it
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            len       <= '0;
            tok_valid <= 1'b0;
            tok       <= TOK_OTHER;
            word_len  <= '0;
        end else begin
            tok_valid <= 1'b0;
            if (in_valid && is_letter) begin
                state <= next_state(state, folded);
                len   <= &len ? len : len + 1'b1;
            end else if (in_valid && state != S_IDLE) begin
                tok_valid <= 1'b1;
                tok       <= tok_of(state);
                word_len  <= len;
                state     <= S_IDLE;
                len       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_keyword_tokenizer.sv
// tb_keyword_tokenizer: directed strings against a scoreboard of expected tokens
module tb_keyword_tokenizer;
    import tokenizer_pkg::*;

    typedef struct {
        logic [1:0] t;
        logic [4:0] l;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in = 8'h00;
    logic       in_valid = 1'b0;
    logic       tok_valid;
    tok_t       tok;
    logic [4:0] word_len;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    keyword_tokenizer #(.LEN_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .in_valid (in_valid),
        .tok_valid(tok_valid),
        .tok      (tok),
        .word_len (word_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] c, input logic v);
        @(negedge clk);
        in = c;
        in_valid = v;
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) put(s[i], 1'b1);
    endtask

    task automatic push(input logic [1:0] t, input logic [4:0] l);
        exp_t e;
        e.t = t;
        e.l = l;
        q.push_back(e);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 4; i++) put(8'h00, 1'b0);
        check(tag, q.size(), 0);
    endtask

    // Every strobe must match the oldest outstanding expectation; an extra strobe is a failure
    always @(negedge clk) begin
        if (tok_valid) begin
            if (q.size() == 0) check("spurious_tok_valid", tok_valid, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                check("tok", tok, e.t);
                check("word_len", word_len, e.l);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_tok_valid", tok_valid, 0);
        check("reset_tok", tok, TOK_OTHER);
        check("reset_word_len", word_len, 0);
        reset = 1'b0;

        push(TOK_BEGIN, 5);
        send("begin");
        put(" ", 1'b1);
        @(posedge clk);
        #1 check("latency_strobe", tok_valid, 1);
        put(8'h00, 1'b0);
        @(posedge clk);
        #1 check("single_cycle_strobe", tok_valid, 0);
        drain("drain_begin");

        push(TOK_END, 3);
        push(TOK_BEGIN, 5);
        send("EnD,BeGiN!");
        drain("drain_mixed_case");

        push(TOK_OTHER, 9);
        push(TOK_END, 3);
        push(TOK_OTHER, 4);
        push(TOK_OTHER, 2);
        push(TOK_OTHER, 1);
        send("beginning end begi en x ");
        drain("drain_prefixes");

        send("  ,,  end");
        drain("drain_pending_word");
        push(TOK_END, 3);
        send(" ");
        drain("drain_late_delim");

        push(TOK_BEGIN, 5);
        send("be");
        repeat (3) put("x", 1'b0);
        send("gin ");
        drain("drain_gap");

        send("beg");
        @(negedge clk);
        reset = 1'b1;
        in = "i";
        in_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midword_reset_tok_valid", tok_valid, 0);
        in = " ";
        drain("drain_reset_discard");

        push(TOK_OTHER, 31);
        for (int i = 0; i < 40; i++) put("a", 1'b1);
        send(" ");
        drain("drain_saturate");

        push(TOK_END, 3);
        send("end");
        put(8'h00, 1'b1);
        drain("drain_nul_delim");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
